// File: rtl/pong_pkg.sv
// Shared pong definitions: life-controller state encoding and lives sizing,
// also used by the heart renderer.
package pong_pkg;

  localparam int LIVES_W           = 2;
  localparam int MAX_LIVES_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    PENALTY = 2'd2,
    OVER    = 2'd3
  } life_state_t;

endpackage

// File: rtl/frame_timer.sv
// Frame-tick driven modulo-LENGTH counter; done pulses on the tick that
// completes a full LENGTH-tick period.
module frame_timer #(
  parameter int LENGTH = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic done
);

  localparam int W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [W-1:0] LAST = W'(LENGTH - 1);

  logic [W-1:0] cnt_reg;

  assign done = tick && (cnt_reg == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= done ? '0 : cnt_reg + W'(1);
    end
  end

endmodule

// File: rtl/life_controller.sv
// Player-lives sequencer: miss handling, penalty hold with blinking lost heart,
// game over. Optional extra-life award enabled by LIFE_CTRL_EXTRA_LIFE_EN.
module life_controller
  import pong_pkg::*;
#(
  parameter int MAX_LIVES      = MAX_LIVES_DEFAULT,
  parameter int PENALTY_FRAMES = 60,
  parameter int BLINK_HALF     = 8,
  parameter int EXTRA_LIFE_PTS = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               miss,
  input  logic               score_tick,
  output logic [LIVES_W-1:0] lives,
  output logic [LIVES_W-1:0] lives_disp,
  output logic               freeze,
  output logic               game_over,
  output logic               playing
);

  localparam logic [LIVES_W-1:0] MAX_L = LIVES_W'(MAX_LIVES);
  localparam logic [LIVES_W-1:0] ONE_L = LIVES_W'(1);

  life_state_t        state_reg, state_next;
  logic [LIVES_W-1:0] lives_reg, lives_next;
  logic [LIVES_W-1:0] disp_reg, disp_next;
  logic               phase_reg, phase_next;
  logic               freeze_reg, game_over_reg, playing_reg;

  logic timer_clr;
  logic timer_tick;
  logic penalty_done;
  logic blink_done;
  logic game_start;
  logic award;

  assign timer_tick = frame_tick && (state_reg == PENALTY);
  assign game_start = start && ((state_reg == IDLE) || (state_reg == OVER));

  frame_timer #(.LENGTH(PENALTY_FRAMES)) u_penalty_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .tick (timer_tick),
    .done (penalty_done)
  );

  frame_timer #(.LENGTH(BLINK_HALF)) u_blink_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .tick (timer_tick),
    .done (blink_done)
  );

`ifdef LIFE_CTRL_EXTRA_LIFE_EN
  localparam int PTS_W = (EXTRA_LIFE_PTS > 1) ? $clog2(EXTRA_LIFE_PTS) : 1;
  localparam logic [PTS_W-1:0] PTS_LAST = PTS_W'(EXTRA_LIFE_PTS - 1);

  logic [PTS_W-1:0] pts_reg;
  logic             pts_tick;

  assign pts_tick = score_tick && (state_reg == PLAY);
  assign award    = pts_tick && (pts_reg == PTS_LAST);

  always_ff @(posedge clk) begin
    if (rst || game_start) begin
      pts_reg <= '0;
    end else if (pts_tick) begin
      pts_reg <= award ? '0 : pts_reg + PTS_W'(1);
    end
  end
`else
  logic unused_extra_life;
  assign unused_extra_life = score_tick ^ EXTRA_LIFE_PTS[0];
  assign award = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    lives_next = lives_reg;
    phase_next = phase_reg;
    timer_clr  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = PLAY;
          lives_next = MAX_L;
        end
      end
      PLAY: begin
        if (miss) begin
          // A coinciding award cancels the lost life but the hold still runs.
          if (award || (lives_reg > ONE_L)) begin
            lives_next = award ? lives_reg : lives_reg - ONE_L;
            state_next = PENALTY;
            phase_next = 1'b1;
            timer_clr  = 1'b1;
          end else begin
            lives_next = '0;
            state_next = OVER;
          end
        end else if (award && (lives_reg < MAX_L)) begin
          lives_next = lives_reg + ONE_L;
        end
      end
      PENALTY: begin
        if (blink_done) begin
          phase_next = ~phase_reg;
        end
        if (penalty_done) begin
          state_next = PLAY;
        end
      end
      OVER: begin
        if (start) begin
          state_next = PLAY;
          lives_next = MAX_L;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Display is derived from next-state values so it updates with the registers.
  always_comb begin
    disp_next = lives_next;
    if (state_next == OVER) begin
      disp_next = '0;
    end else if ((state_next == PENALTY) && phase_next && (lives_next < MAX_L)) begin
      disp_next = lives_next + ONE_L;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      lives_reg     <= MAX_L;
      disp_reg      <= MAX_L;
      phase_reg     <= 1'b0;
      freeze_reg    <= 1'b1;
      game_over_reg <= 1'b0;
      playing_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lives_reg     <= lives_next;
      disp_reg      <= disp_next;
      phase_reg     <= phase_next;
      freeze_reg    <= (state_next != PLAY);
      game_over_reg <= (state_next == OVER);
      playing_reg   <= (state_next == PLAY);
    end
  end

  assign lives      = lives_reg;
  assign lives_disp = disp_reg;
  assign freeze     = freeze_reg;
  assign game_over  = game_over_reg;
  assign playing    = playing_reg;

endmodule

// File: tb/tb_life_controller.sv
// Randomized and scenario-driven bench for life_controller against a
// frame-counting reference model; follows LIFE_CTRL_EXTRA_LIFE_EN if defined.
module tb_life_controller;

  localparam int MAXL = 3;
  localparam int PEN  = 60;
  localparam int BLK  = 8;
  localparam int PTS  = 10;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_PEN  = 2;
  localparam int M_OVER = 3;

`ifdef LIFE_CTRL_EXTRA_LIFE_EN
  localparam bit EXTRA = 1'b1;
`else
  localparam bit EXTRA = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       miss = 1'b0;
  logic       score_tick = 1'b0;
  logic [1:0] lives;
  logic [1:0] lives_disp;
  logic       freeze;
  logic       game_over;
  logic       playing;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: game mode, lives, frames elapsed in the hold, points.
  int m_mode   = M_IDLE;
  int m_lives  = MAXL;
  int m_frames = 0;
  int m_pts    = 0;

  always #5 clk = ~clk;

  life_controller dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (start),
    .miss       (miss),
    .score_tick (score_tick),
    .lives      (lives),
    .lives_disp (lives_disp),
    .freeze     (freeze),
    .game_over  (game_over),
    .playing    (playing)
  );

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_vec++;
    if (got !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_disp();
    int d;
    if (m_mode == M_OVER) return 0;
    if (m_mode != M_PEN) return m_lives;
    // Lost heart shown during even half-periods of the hold.
    d = ((m_frames / BLK) % 2 == 0) ? m_lives + 1 : m_lives;
    return (d > MAXL) ? MAXL : d;
  endfunction

  task automatic model_step(input bit r, input bit ft, input bit st, input bit ms, input bit sc);
    bit aw;
    if (r) begin
      m_mode = M_IDLE; m_lives = MAXL; m_frames = 0; m_pts = 0;
      return;
    end
    case (m_mode)
      M_IDLE, M_OVER: if (st) begin
        m_mode = M_PLAY; m_lives = MAXL; m_pts = 0;
      end
      M_PLAY: begin
        aw = 1'b0;
        if (EXTRA && sc) begin
          m_pts = m_pts + 1;
          if (m_pts == PTS) begin aw = 1'b1; m_pts = 0; end
        end
        if (ms) begin
          if (aw || m_lives > 1) begin
            if (!aw) m_lives = m_lives - 1;
            m_mode = M_PEN; m_frames = 0;
          end else begin
            m_lives = 0; m_mode = M_OVER;
          end
        end else if (aw && m_lives < MAXL) begin
          m_lives = m_lives + 1;
        end
      end
      default: if (ft) begin
        m_frames = m_frames + 1;
        if (m_frames == PEN) m_mode = M_PLAY;
      end
    endcase
  endtask

  task automatic step(input bit r, input bit ft, input bit st, input bit ms, input bit sc);
    rst = r; frame_tick = ft; start = st; miss = ms; score_tick = sc;
    @(posedge clk);
    model_step(r, ft, st, ms, sc);
    #1;
    rst = 1'b0; frame_tick = 1'b0; start = 1'b0; miss = 1'b0; score_tick = 1'b0;
    check("lives", lives, m_lives);
    check("lives_disp", lives_disp, model_disp());
    check("freeze", freeze, (m_mode != M_PLAY) ? 1 : 0);
    check("game_over", game_over, (m_mode == M_OVER) ? 1 : 0);
    check("playing", playing, (m_mode == M_PLAY) ? 1 : 0);
  endtask

  // Frame ticks separated by an idle cycle, bounded to avoid runaway loops.
  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1);
    check("rst_lives", lives, 3);
    check("rst_disp", lives_disp, 3);
    check("rst_freeze", freeze, 1);
    $display("txn reset: lives=%0d disp=%0d freeze=%0d", lives, lives_disp, freeze);

    step(0, 0, 0, 1, 0);
    check("idle_miss_ignored", lives, 3);
    step(0, 0, 1, 0, 0);
    check("start_playing", playing, 1);
    $display("txn start: playing=%0d lives=%0d", playing, lives);

    step(0, 0, 0, 1, 0);
    check("miss_lives", lives, 2);
    check("miss_disp_blink_on", lives_disp, 3);
    run_frames(8);
    check("blink_off_frame8", lives_disp, 2);
    run_frames(12);
    step(0, 0, 1, 1, 0);
    check("pen_miss_ignored", lives, 2);
    run_frames(39);
    check("pen_still_frozen", freeze, 1);
    run_frames(1);
    check("pen_done_playing", playing, 1);
    check("pen_done_disp", lives_disp, 2);
    step(0, 0, 1, 0, 0);
    $display("txn penalty: lives=%0d playing=%0d", lives, playing);

    for (int k = 0; k < 3 && m_mode != M_OVER; k++) begin
      step(0, 0, 0, 1, 0);
      for (int f = 0; f < PEN + 5 && m_mode == M_PEN; f++) step(0, 1, 0, 0, 0);
    end
    check("over_flag", game_over, 1);
    check("over_lives", lives, 0);
    check("over_disp", lives_disp, 0);
    step(0, 0, 1, 1, 0);
    check("restart_lives", lives, 3);
    check("restart_game_over", game_over, 0);
    $display("txn game_over+restart: lives=%0d game_over=%0d", lives, game_over);

    step(0, 0, 0, 1, 0);
    run_frames(30);
    step(1, 1, 0, 0, 0);
    check("midpen_rst_disp", lives_disp, 3);
    check("midpen_rst_freeze", freeze, 1);
    $display("txn reset_in_penalty: lives=%0d disp=%0d", lives, lives_disp);

    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int f = 0; f < PEN + 5 && m_mode == M_PEN; f++) step(0, 1, 0, 0, 0);
    for (int s = 0; s < PTS; s++) step(0, 0, 0, 0, 1);
    check("score10_lives", lives, EXTRA ? 3 : 2);
    for (int s = 0; s < PTS; s++) step(0, 0, 0, 0, 1);
    check("score20_lives", lives, EXTRA ? 3 : 2);
    $display("txn score_ticks: lives=%0d", lives);

    for (int i = 0; i < 20000; i++) begin
      step(($urandom_range(2999) == 0),
           ($urandom_range(2) == 0),
           ($urandom_range(29) == 0),
           ($urandom_range(39) == 0),
           ($urandom_range(3) == 0));
    end
    $display("txn random: 20000 cycles");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
